// File: rtl/rescale_arith_core.sv
// Fixed-point arithmetic core for the image-rescale datapath: a sequential
// signed-magnitude divider, a combinational signed-magnitude adder and a
// combinational RGB565 bilinear-blend unit.

// One colour channel of the blend: weighted sum of four neighbour samples,
// fraction dropped, saturated to the channel width.
module rescale_blend_chan #(
    parameter int W     = 5,
    parameter int Q     = 5,
    parameter int MAG_W = 15
) (
    input  logic [W-1:0]     c0,
    input  logic [W-1:0]     c1,
    input  logic [W-1:0]     c2,
    input  logic [W-1:0]     c3,
    input  logic [MAG_W-1:0] w0,
    input  logic [MAG_W-1:0] w1,
    input  logic [MAG_W-1:0] w2,
    input  logic [MAG_W-1:0] w3,
    input  logic             wneg,
    output logic [W-1:0]     value,
    output logic             err
);

    // Two guard bits cover the four-term sum, so the accumulator never wraps.
    localparam int ACC_W = W + MAG_W + 2;
    localparam logic [ACC_W-1:0] MAX_VAL = ACC_W'((1 << W) - 1);

    function automatic logic [ACC_W-1:0] weighted_sum(
        input logic [W-1:0]     s0, input logic [W-1:0]     s1,
        input logic [W-1:0]     s2, input logic [W-1:0]     s3,
        input logic [MAG_W-1:0] k0, input logic [MAG_W-1:0] k1,
        input logic [MAG_W-1:0] k2, input logic [MAG_W-1:0] k3);
        return ACC_W'(s0) * ACC_W'(k0) + ACC_W'(s1) * ACC_W'(k1)
             + ACC_W'(s2) * ACC_W'(k2) + ACC_W'(s3) * ACC_W'(k3);
    endfunction

    // Returns {err, value}; a negative weight is treated as an error too.
    function automatic logic [W:0] saturate(input logic [ACC_W-1:0] acc,
                                            input logic neg);
        logic [ACC_W-1:0] scaled;
        logic [W:0]       res;
        scaled = acc >> Q;
        if (neg || (scaled > MAX_VAL)) res = {1'b1, MAX_VAL[W-1:0]};
        else                           res = {1'b0, scaled[W-1:0]};
        return res;
    endfunction

    assign {err, value} = saturate(weighted_sum(c0, c1, c2, c3, w0, w1, w2, w3), wneg);

endmodule

module rescale_arith_core #(
    parameter int Q = 5,
    parameter int N = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] div_dividend,
    input  logic [N-1:0] div_divisor,
    input  logic         div_start,
    output logic [N-1:0] div_quotient,
    output logic         div_complete,
    output logic         div_overflow,
    input  logic [N-1:0] add_a,
    input  logic [N-1:0] add_b,
    output logic [N-1:0] add_sum,
    input  logic [15:0]  n0,
    input  logic [15:0]  n1,
    input  logic [15:0]  n2,
    input  logic [15:0]  n3,
    input  logic [N-1:0] m3,
    input  logic [N-1:0] m4,
    input  logic [N-1:0] m5,
    input  logic [N-1:0] m6,
    output logic [4:0]   red,
    output logic [5:0]   green,
    output logic [4:0]   blue,
    output logic         pixel_err
);

    localparam int MAG_W = N - 1;
    localparam int NUM_W = MAG_W + Q;         // quotient bits produced, one per cycle
    localparam int CNT_W = $clog2(NUM_W + 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} div_state_t;

    div_state_t         state, state_nx;
    logic               accept, last_iter;
    logic [NUM_W-1:0]   num_p0;
    logic [MAG_W-1:0]   dvs_p0;
    logic [MAG_W-1:0]   rem_p0;
    logic [NUM_W-2:0]   quo_p0;
    logic               sign_p0;
    logic [CNT_W-1:0]   cnt_p0;
    logic [MAG_W:0]     rem_sh;
    logic               rem_ge;
    logic [MAG_W-1:0]   rem_diff, rem_nx;
    logic [NUM_W-1:0]   quo_nx;
    logic               ovf_nx;
    logic [MAG_W-1:0]   mag_nx;
    logic               err_r, err_g, err_b, wneg;

    function automatic logic [N-1:0] add_sm(input logic [N-1:0] a, input logic [N-1:0] b);
        logic [MAG_W-1:0] mag;
        logic             sgn;
        if (a[N-1] == b[N-1]) begin
            mag = a[MAG_W-1:0] + b[MAG_W-1:0];
            sgn = a[N-1];
        end else if (a[MAG_W-1:0] >= b[MAG_W-1:0]) begin
            mag = a[MAG_W-1:0] - b[MAG_W-1:0];
            sgn = a[N-1];
        end else begin
            mag = b[MAG_W-1:0] - a[MAG_W-1:0];
            sgn = b[N-1];
        end
        if (mag == '0) sgn = 1'b0;
        return {sgn, mag};
    endfunction

    assign add_sum = add_sm(add_a, add_b);

    // Divider state register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    // Divider next state; DONE accepts a start like IDLE so a held start gives a one-cycle complete.
    always_comb begin
        state_nx  = state;
        accept    = 1'b0;
        last_iter = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                accept   = div_start;
                state_nx = div_start ? BUSY : IDLE;
            end
            BUSY: begin
                if (cnt_p0 == CNT_W'(NUM_W - 1)) begin
                    last_iter = 1'b1;
                    state_nx  = DONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // One restoring shift-subtract step; the remainder stays below the divisor,
    // so the low MAG_W bits of the difference are exact whenever it is taken.
    always_comb begin
        rem_sh   = {rem_p0, num_p0[NUM_W-1]};
        rem_ge   = rem_sh >= {1'b0, dvs_p0};
        rem_diff = rem_sh[MAG_W-1:0] - dvs_p0;
        rem_nx   = rem_ge ? rem_diff : rem_sh[MAG_W-1:0];
        quo_nx   = {quo_p0, rem_ge};
        ovf_nx   = (dvs_p0 == '0) || (quo_nx[NUM_W-1:MAG_W] != '0);
        mag_nx   = ovf_nx ? '1 : quo_nx[MAG_W-1:0];
    end

    // Operand latch and iteration registers.
    always_ff @(posedge clock) begin
        if (accept) begin
            num_p0  <= {div_dividend[MAG_W-1:0], Q'(0)};
            dvs_p0  <= div_divisor[MAG_W-1:0];
            sign_p0 <= div_dividend[N-1] ^ div_divisor[N-1];
            rem_p0  <= '0;
            quo_p0  <= '0;
            cnt_p0  <= '0;
        end else if (state == BUSY) begin
            num_p0  <= num_p0 << 1;
            rem_p0  <= rem_nx;
            quo_p0  <= quo_nx[NUM_W-2:0];
            cnt_p0  <= cnt_p0 + 1'b1;
        end
    end

    // Result registers: cleared on accept (complete only), loaded on the last step.
    always_ff @(posedge clock) begin
        if (reset) begin
            div_quotient <= '0;
            div_complete <= 1'b0;
            div_overflow <= 1'b0;
        end else if (accept) begin
            div_complete <= 1'b0;
        end else if (last_iter) begin
            div_quotient <= {sign_p0, mag_nx};
            div_overflow <= ovf_nx;
            div_complete <= 1'b1;
        end
    end

    assign wneg = m3[N-1] | m4[N-1] | m5[N-1] | m6[N-1];

    rescale_blend_chan #(.W(5), .Q(Q), .MAG_W(MAG_W)) u_red (
        .c0(n0[15:11]), .c1(n1[15:11]), .c2(n2[15:11]), .c3(n3[15:11]),
        .w0(m3[MAG_W-1:0]), .w1(m4[MAG_W-1:0]), .w2(m5[MAG_W-1:0]), .w3(m6[MAG_W-1:0]),
        .wneg(wneg), .value(red), .err(err_r)
    );

    rescale_blend_chan #(.W(6), .Q(Q), .MAG_W(MAG_W)) u_green (
        .c0(n0[10:5]), .c1(n1[10:5]), .c2(n2[10:5]), .c3(n3[10:5]),
        .w0(m3[MAG_W-1:0]), .w1(m4[MAG_W-1:0]), .w2(m5[MAG_W-1:0]), .w3(m6[MAG_W-1:0]),
        .wneg(wneg), .value(green), .err(err_g)
    );

    rescale_blend_chan #(.W(5), .Q(Q), .MAG_W(MAG_W)) u_blue (
        .c0(n0[4:0]), .c1(n1[4:0]), .c2(n2[4:0]), .c3(n3[4:0]),
        .w0(m3[MAG_W-1:0]), .w1(m4[MAG_W-1:0]), .w2(m5[MAG_W-1:0]), .w3(m6[MAG_W-1:0]),
        .wneg(wneg), .value(blue), .err(err_b)
    );

    assign pixel_err = err_r | err_g | err_b;

endmodule

// File: tb/tb_rescale_arith_core.sv
// Self-checking bench for rescale_arith_core: directed cases plus randomized
// stimulus compared against an arithmetic reference model.
module tb_rescale_arith_core;

    localparam int Q = 5;
    localparam int N = 16;

    logic         clock = 1'b0;
    logic         reset;
    logic [N-1:0] div_dividend, div_divisor, div_quotient;
    logic         div_start, div_complete, div_overflow;
    logic [N-1:0] add_a, add_b, add_sum;
    logic [15:0]  n0, n1, n2, n3;
    logic [N-1:0] m3, m4, m5, m6;
    logic [4:0]   red, blue;
    logic [5:0]   green;
    logic         pixel_err;

    int n_checks = 0;
    int n_fail   = 0;

    rescale_arith_core #(.Q(Q), .N(N)) dut (
        .clock(clock), .reset(reset),
        .div_dividend(div_dividend), .div_divisor(div_divisor), .div_start(div_start),
        .div_quotient(div_quotient), .div_complete(div_complete), .div_overflow(div_overflow),
        .add_a(add_a), .add_b(add_b), .add_sum(add_sum),
        .n0(n0), .n1(n1), .n2(n2), .n3(n3),
        .m3(m3), .m4(m4), .m5(m5), .m6(m6),
        .red(red), .green(green), .blue(blue), .pixel_err(pixel_err)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- reference models ----------------
    function automatic logic [15:0] add_model(input logic [15:0] a, input logic [15:0] b);
        int am, bm, r, mag;
        logic sgn;
        am = int'(a[14:0]);
        bm = int'(b[14:0]);
        if (a[15] == b[15]) begin
            mag = (am + bm) % 32768;
            sgn = (mag == 0) ? 1'b0 : a[15];
        end else begin
            r   = (a[15] ? -am : am) + (b[15] ? -bm : bm);
            sgn = (r < 0);
            mag = (r < 0) ? -r : r;
        end
        return {sgn, 15'(mag)};
    endfunction

    // Returns {overflow, quotient}.
    function automatic logic [16:0] div_model(input logic [15:0] a, input logic [15:0] b);
        longint dm, vm, q;
        logic [14:0] mag;
        logic ovf;
        dm = longint'(a[14:0]);
        vm = longint'(b[14:0]);
        if (vm == 0) begin
            ovf = 1'b1;
            mag = 15'h7FFF;
        end else begin
            q = (dm * (64'sd1 << Q)) / vm;
            if (q > 32767) begin
                ovf = 1'b1;
                mag = 15'h7FFF;
            end else begin
                ovf = 1'b0;
                mag = 15'(q);
            end
        end
        return {ovf, a[15] ^ b[15], mag};
    endfunction

    // Returns {err, red, green, blue}.
    function automatic logic [16:0] blend_model(input logic [15:0] p0, input logic [15:0] p1,
                                                input logic [15:0] p2, input logic [15:0] p3,
                                                input logic [15:0] w0, input logic [15:0] w1,
                                                input logic [15:0] w2, input logic [15:0] w3);
        int pix[4], wt[4], width[3], off[3], res[3];
        logic neg, err;
        pix = '{int'(p0), int'(p1), int'(p2), int'(p3)};
        wt  = '{int'(w0), int'(w1), int'(w2), int'(w3)};
        width = '{5, 6, 5};
        off   = '{11, 5, 0};
        neg = 1'b0;
        for (int k = 0; k < 4; k++) if (wt[k] >= 32768) neg = 1'b1;
        err = 1'b0;
        for (int ch = 0; ch < 3; ch++) begin
            int acc, mx;
            acc = 0;
            mx  = (1 << width[ch]) - 1;
            for (int k = 0; k < 4; k++)
                acc += ((pix[k] >> off[ch]) & mx) * (wt[k] % 32768);
            res[ch] = acc / (1 << Q);
            if (neg || res[ch] > mx) begin
                res[ch] = mx;
                err = 1'b1;
            end
        end
        return {err, 5'(res[0]), 6'(res[1]), 5'(res[2])};
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic wait_done(output int lat);
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clock); #1;
            if (div_complete) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic start_div(input logic [15:0] a, input logic [15:0] b);
        @(negedge clock);
        div_dividend = a;
        div_divisor  = b;
        div_start    = 1'b1;
        @(posedge clock); #1;
        div_start    = 1'b0;
        div_dividend = 16'($urandom);
        div_divisor  = 16'($urandom);
    endtask

    task automatic run_div(input logic [15:0] a, input logic [15:0] b,
                           input logic [15:0] exp_q, input logic exp_ovf, input string tag);
        int lat;
        start_div(a, b);
        check({tag, "_cmpl_drop"}, div_complete, 0);
        wait_done(lat);
        check({tag, "_latency"}, lat, 20);
        check({tag, "_quot"}, div_quotient, exp_q);
        check({tag, "_ovf"}, div_overflow, exp_ovf);
    endtask

    task automatic blend_set(input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] p2, input logic [15:0] p3,
                             input logic [15:0] w0, input logic [15:0] w1,
                             input logic [15:0] w2, input logic [15:0] w3);
        n0 = p0; n1 = p1; n2 = p2; n3 = p3;
        m3 = w0; m4 = w1; m5 = w2; m6 = w3;
        #1;
    endtask

    function automatic logic [15:0] rand_weight();
        logic [15:0] w;
        w = 16'($urandom_range(0, 12));
        if ($urandom_range(0, 7) == 0) w = 16'($urandom_range(0, 120));
        if ($urandom_range(0, 9) == 0) w[15] = 1'b1;
        return w;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [15:0] a, b;
        logic [16:0] dexp;
        int lat, seen;

        reset = 1'b1;
        div_start = 1'b0; div_dividend = '0; div_divisor = '0;
        add_a = '0; add_b = '0;
        n0 = '0; n1 = '0; n2 = '0; n3 = '0;
        m3 = '0; m4 = '0; m5 = '0; m6 = '0;

        repeat (3) @(posedge clock);
        #1;
        check("rst_quot", div_quotient, 16'h0000);
        check("rst_cmpl", div_complete, 0);
        check("rst_ovf", div_overflow, 0);
        add_a = 16'h0020; add_b = 16'h8008; #1;
        check("add_during_reset", add_sum, 16'h0018);
        @(negedge clock);
        reset = 1'b0;

        // Adder
        add_a = 16'h0008; add_b = 16'h8008; #1;
        check("add_cancel_zero", add_sum, 16'h0000);
        add_a = 16'h8020; add_b = 16'h8010; #1;
        check("add_neg_neg", add_sum, 16'h8030);
        add_a = 16'h7FFF; add_b = 16'h0002; #1;
        check("add_trunc", add_sum, 16'h0001);
        for (int i = 0; i < 40; i++) begin
            add_a = 16'($urandom);
            add_b = (i % 8 == 0) ? {~add_a[15], add_a[14:0]} : 16'($urandom);
            #1;
            check("add_rand", add_sum, add_model(add_a, add_b));
        end

        // Blend
        blend_set(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0020, 16'h0, 16'h0, 16'h0);
        check("blend_unity_r", red, 31);
        check("blend_unity_g", green, 63);
        check("blend_unity_b", blue, 31);
        check("blend_unity_err", pixel_err, 0);
        blend_set(16'hF800, 16'h0000, 16'h0000, 16'h0000, 16'h0010, 16'h0010, 16'h0, 16'h0);
        check("blend_half", {red, green, blue, pixel_err}, {5'd15, 6'd0, 5'd0, 1'b0});
        blend_set(16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0020, 16'h0020, 16'h0020, 16'h0020);
        check("blend_sat", {red, green, blue, pixel_err}, {5'd31, 6'd63, 5'd31, 1'b1});
        blend_set(16'h1234, 16'h0000, 16'h0000, 16'h0000, 16'h0008, 16'h0, 16'h8010, 16'h0);
        check("blend_negw_err", pixel_err, 1);
        check("blend_negw_r", red, 31);
        for (int i = 0; i < 40; i++) begin
            blend_set(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom),
                      rand_weight(), rand_weight(), rand_weight(), rand_weight());
            check("blend_rand", {pixel_err, red, green, blue},
                  blend_model(n0, n1, n2, n3, m3, m4, m5, m6));
        end

        // Divider, directed
        run_div(16'h2800, 16'h1900, 16'h0033, 1'b0, "div_320_200");
        repeat (3) @(posedge clock);
        #1;
        check("div_hold_cmpl", div_complete, 1);
        check("div_hold_quot", div_quotient, 16'h0033);
        run_div(16'h1E00, 16'h3C00, 16'h0010, 1'b0, "div_240_480");
        run_div(16'h2800, 16'h9900, 16'h8033, 1'b1 ^ 1'b1, "div_neg");
        run_div(16'h2800, 16'h0001, 16'h7FFF, 1'b1, "div_ovf");
        run_div(16'h2800, 16'h0000, 16'h7FFF, 1'b1, "div_zero");

        // Reset in the middle of a division
        run_div(16'h1E00, 16'h3C00, 16'h0010, 1'b0, "div_pre_rst");
        start_div(16'h2800, 16'h1900);
        repeat (9) @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clock); #1;
            if (div_complete) seen = 1;
        end
        check("rst_abort_cmpl", seen, 0);
        check("rst_abort_quot", div_quotient, 16'h0000);

        // Start pulse while busy is ignored
        start_div(16'h2800, 16'h1900);
        repeat (5) @(posedge clock);
        @(negedge clock);
        div_dividend = 16'h1E00; div_divisor = 16'h0001; div_start = 1'b1;
        @(posedge clock); #1;
        div_start = 1'b0;
        wait_done(lat);
        check("busy_start_latency", (lat < 0) ? lat : lat + 6, 20);
        check("busy_start_quot", div_quotient, 16'h0033);
        check("busy_start_ovf", div_overflow, 0);

        // Start held high: back-to-back divisions, complete high one cycle
        @(negedge clock);
        div_dividend = 16'h1E00; div_divisor = 16'h3C00; div_start = 1'b1;
        @(posedge clock); #1;
        wait_done(lat);
        check("held_first_latency", lat, 20);
        check("held_first_quot", div_quotient, 16'h0010);
        @(posedge clock); #1;
        check("held_cmpl_pulse", div_complete, 0);
        div_start = 1'b0;
        wait_done(lat);
        check("held_second_latency", lat, 20);
        check("held_second_quot", div_quotient, 16'h0010);

        // Divider, randomized
        for (int i = 0; i < 16; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i % 4 == 0) b[14:0] = 15'($urandom_range(0, 40));
            dexp = div_model(a, b);
            run_div(a, b, dexp[15:0], dexp[16], "div_rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
